hdmi_pattern_sequencer: RTL and testbench

Frame-synchronous test-pattern controller for the HDMI output path. It sits between the HDMI transmitter's pixel-position outputs (`row`, `column`) and its `r`/`g`/`b` inputs, in the `pix_clk` domain. It generates one of four patterns and advances the selection automatically every N frames or on a manual request. Pattern changes always take effect at a frame boundary.

---
 rtl/hdmi_pattern_sequencer.sv | 171 +++++++++++++++++
 tb/tb_hdmi_pattern_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_sequencer.sv
// Frame-synchronous HDMI test-pattern generator: gradient, colour bars, checkerboard
// and moving box, advanced every FRAMES_PER_PATTERN frames or on a manual request.
module hdmi_pattern_sequencer #(
   parameter int HACTIVE            = 1280,
   parameter int VACTIVE            = 720,
   parameter int FRAMES_PER_PATTERN = 120
) (
   input  logic        pix_clk,
   input  logic        reset_n,
   input  logic [10:0] row,
   input  logic [10:0] column,
   input  logic        auto_en,
   input  logic        next_req,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic [1:0]  pattern,
   output logic        sof
);

   localparam logic [10:0] H_END      = 11'(HACTIVE);
   localparam logic [10:0] V_END      = 11'(VACTIVE);
   localparam logic [10:0] BAR_W      = 11'(HACTIVE / 8);
   localparam logic [10:0] BOX_TOP    = 11'(VACTIVE / 2 - 32);
   localparam logic [10:0] BOX_BOT    = 11'(VACTIVE / 2 + 31);
   localparam logic [10:0] BOX_X_MAX  = 11'(HACTIVE - 64);
   localparam logic [15:0] CNT_LAST   = 16'(FRAMES_PER_PATTERN - 1);
   localparam logic [23:0] WHITE      = 24'hFF_FF_FF;
   localparam logic [23:0] BACKGROUND = 24'h00_00_80;

   typedef enum logic {
      RUN     = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        advance;

   logic        origin;
   logic        was_origin;
   logic        sof_det;

   logic [15:0] frame_cnt;
   logic [15:0] frame_cnt_nxt;
   logic [1:0]  pattern_nxt;
   logic [10:0] box_x;
   logic [10:0] box_x_nxt;
   logic [2:0]  bar_idx;

   logic [23:0] rgb_p0;
   logic [23:0] rgb_p1;
   logic        sof_p1;

   function automatic logic [23:0] bar_colour(input logic [2:0] bar);
      logic [23:0] c;
      case (bar)
         3'd0:    c = 24'hFF_FF_FF;
         3'd1:    c = 24'hFF_FF_00;
         3'd2:    c = 24'h00_FF_FF;
         3'd3:    c = 24'h00_FF_00;
         3'd4:    c = 24'hFF_00_FF;
         3'd5:    c = 24'hFF_00_00;
         3'd6:    c = 24'h00_00_FF;
         default: c = 24'h00_00_00;
      endcase
      return c;
   endfunction

   function automatic logic [23:0] render(input logic [10:0] y,
                                          input logic [10:0] x,
                                          input logic [1:0]  pat,
                                          input logic [10:0] bx,
                                          input logic [2:0]  bar);
      logic [23:0] c;
      logic        in_box;
      c      = '0;
      in_box = (y >= BOX_TOP) && (y <= BOX_BOT) && (x >= bx) && (x <= bx + 11'd63);
      if ((y < V_END) && (x < H_END)) begin
         case (pat)
            2'd0:    c = {y[7:0], x[7:0], 8'(8'd255 - {1'b0, y[7:1]} - {1'b0, x[7:1]})};
            2'd1:    c = bar_colour(bar);
            2'd2:    c = (y[5] ^ x[5]) ? WHITE : 24'h0;
            default: c = in_box ? WHITE : BACKGROUND;
         endcase
      end
      return c;
   endfunction

   // Origin edge detect: a held origin yields a single start-of-frame.
   assign origin  = (row == 11'd0) && (column == 11'd0);
   assign sof_det = origin && !was_origin;

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (next_req) state_nxt = PENDING;
         end
         PENDING: begin
            if (sof_det && !next_req) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      advance = 1'b0;
      if (sof_det) begin
         advance = (state == PENDING) || (auto_en && (frame_cnt == CNT_LAST));
      end
   end

   always_comb begin
      pattern_nxt   = advance ? pattern + 2'd1 : pattern;
      frame_cnt_nxt = frame_cnt;
      box_x_nxt     = box_x;
      if (sof_det) begin
         if (advance)      frame_cnt_nxt = 16'd0;
         else if (auto_en) frame_cnt_nxt = frame_cnt + 16'd1;
         if (pattern_nxt == 2'd3) begin
            if (pattern != 2'd3)         box_x_nxt = 11'd0;
            else if (box_x == BOX_X_MAX) box_x_nxt = 11'd0;
            else                         box_x_nxt = box_x + 11'd1;
         end
      end
   end

   // Bar index from constant boundaries, so no divider is needed.
   always_comb begin
      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (column >= 11'(i * BAR_W)) bar_idx = 3'(i);
      end
   end

   // The origin pixel already uses the post-advance pattern and box position.
   assign rgb_p0 = render(row, column, pattern_nxt, box_x_nxt, bar_idx);

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         was_origin <= 1'b0;
         frame_cnt  <= 16'd0;
         pattern    <= 2'd0;
         box_x      <= 11'd0;
         sof_p1     <= 1'b0;
         rgb_p1     <= 24'd0;
      end else begin
         was_origin <= origin;
         frame_cnt  <= frame_cnt_nxt;
         pattern    <= pattern_nxt;
         box_x      <= box_x_nxt;
         sof_p1     <= sof_det;
         rgb_p1     <= rgb_p0;
      end
   end

   assign r   = rgb_p1[23:16];
   assign g   = rgb_p1[15:8];
   assign b   = rgb_p1[7:0];
   assign sof = sof_p1;

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Scoreboard bench for hdmi_pattern_sequencer: a frame-level reference model predicts
// each output pixel, pattern index and start-of-frame pulse.
module tb_hdmi_pattern_sequencer;

   localparam int H = 1280;
   localparam int V = 720;
   localparam int F = 3;

   logic        pix_clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [10:0] row = 11'd5;
   logic [10:0] column = 11'd7;
   logic        auto_en = 1'b0;
   logic        next_req = 1'b0;
   logic [7:0]  r, g, b;
   logic [1:0]  pattern;
   logic        sof;

   always #5 pix_clk = ~pix_clk;

   hdmi_pattern_sequencer #(
      .HACTIVE(H), .VACTIVE(V), .FRAMES_PER_PATTERN(F)
   ) dut (
      .pix_clk(pix_clk), .reset_n(reset_n), .row(row), .column(column),
      .auto_en(auto_en), .next_req(next_req), .r(r), .g(g), .b(b),
      .pattern(pattern), .sof(sof)
   );

   typedef struct packed {
      logic [23:0] rgb;
      logic [1:0]  pat;
      logic        sof;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   int   m_pat, m_cnt, m_box;
   bit   m_pend, m_prev;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [23:0] ref_colour(input int rw, input int cl, input int p, input int bx);
      logic [2:0] tbl [8];
      logic [2:0] on;
      int         bar;
      tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
      if (rw >= V || cl >= H) return 24'h0;
      case (p)
         0: return {8'(rw % 256), 8'(cl % 256), 8'((255 - (rw % 256) / 2 - (cl % 256) / 2) % 256)};
         1: begin
            bar = cl / (H / 8);
            on  = tbl[bar];
            return {{8{on[2]}}, {8{on[1]}}, {8{on[0]}}};
         end
         2: return (((rw / 32) % 2) != ((cl / 32) % 2)) ? 24'hFFFFFF : 24'h0;
         default: begin
            if (rw >= V / 2 - 32 && rw < V / 2 + 32 && cl >= bx && cl < bx + 64) return 24'hFFFFFF;
            return 24'h000080;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_pat = 0; m_cnt = 0; m_box = 0; m_pend = 0; m_prev = 0;
   endtask

   // One pixel cycle: drive inputs and queue the response due after the next edge.
   task automatic pix(input int rw, input int cl, input bit req = 1'b0);
      bit origin, sofd;
      int old;
      @(negedge pix_clk);
      row      = 11'(rw);
      column   = 11'(cl);
      next_req = req;
      origin   = (rw == 0) && (cl == 0);
      sofd     = origin && !m_prev;
      m_prev   = origin;
      if (sofd) begin
         old = m_pat;
         if (m_pend || (auto_en && m_cnt == F - 1)) begin
            m_pat = (m_pat + 1) % 4;
            m_cnt = 0;
         end else if (auto_en) begin
            m_cnt++;
         end
         m_pend = req;
         if (m_pat == 3) m_box = (old != 3) ? 0 : ((m_box == H - 64) ? 0 : m_box + 1);
      end else if (req) begin
         m_pend = 1;
      end
      sb.push_back({ref_colour(rw, cl, m_pat, m_box), 2'(m_pat), sofd});
   endtask

   task automatic frame(input int hold, input int len, input int req_pct);
      int rw, cl;
      for (int i = 0; i < hold; i++) pix(0, 0);
      for (int i = 0; i < len; i++) begin
         rw = $urandom_range(0, 799);
         cl = $urandom_range(0, 1400);
         if (rw == 0 && cl == 0) cl = 1;
         pix(rw, cl, $urandom_range(0, 99) < req_pct);
      end
   endtask

   task automatic do_reset(input int rw, input int cl);
      @(negedge pix_clk);
      reset_n  = 1'b0;
      row      = 11'(rw);
      column   = 11'(cl);
      next_req = 1'b0;
      #1;
      check("reset_rgb", {r, g, b}, 0);
      check("reset_pattern", pattern, 0);
      check("reset_sof", sof, 0);
      @(negedge pix_clk);
      check("reset_rgb_held", {r, g, b}, 0);
      @(negedge pix_clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   always @(posedge pix_clk) begin
      #2;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("rgb", {r, g, b}, e.rgb);
         check("pattern", pattern, e.pat);
         check("sof", sof, e.sof);
      end
   end

   initial begin
      model_reset();
      do_reset(5, 7);
      pix(5, 7);
      pix(5, 7);

      // Auto mode, origin held two cycles per frame.
      auto_en = 1'b1;
      for (int f = 0; f < 7; f++) frame(2, 8, 0);

      // Manual requests: two pulses absorbed, then one coincident with the origin.
      auto_en = 1'b0;
      pix(10, 10); pix(20, 20, 1'b1); pix(30, 30); pix(40, 40, 1'b1);
      frame(1, 4, 0);
      pix(0, 0, 1'b1);
      frame(0, 4, 0);
      frame(1, 4, 0);
      frame(1, 4, 0);

      // Colour-bar boundaries.
      while (m_pat != 1) begin
         pix(100, 100, 1'b1);
         frame(1, 3, 0);
      end
      pix(100, 159); pix(100, 160); pix(100, 1279); pix(100, 1280);
      pix(719, 0); pix(720, 0); pix(50, 640); pix(50, 959);

      // Moving box: entry frame and full wrap of box_x.
      while (m_pat != 3) begin
         pix(100, 100, 1'b1);
         frame(1, 2, 0);
      end
      pix(360, 0); pix(360, 63); pix(360, 64); pix(328, 5); pix(327, 5); pix(391, 5); pix(392, 5);
      for (int f = 0; f < 1220; f++) begin
         pix(0, 0);
         pix(360, m_box);
         pix(360, m_box + 63);
         pix(360, m_box + 64);
      end

      // Reset mid-frame, then auto expiry coinciding with a pending request.
      do_reset(300, 400);
      pix(300, 400);
      auto_en = 1'b1;
      frame(1, 5, 0);
      frame(1, 5, 0);
      pix(10, 10, 1'b1);
      frame(0, 3, 0);
      for (int f = 0; f < 4; f++) frame(1, 5, 0);

      // Randomised mix of modes, hold lengths and requests.
      for (int f = 0; f < 300; f++) begin
         auto_en = 1'($urandom_range(0, 1));
         frame($urandom_range(1, 3), $urandom_range(2, 10), 15);
      end

      repeat (3) @(negedge pix_clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
